// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the fetch port, the data port and the memory side.
// The master modport is the environment, which holds the requesters and the memory.
// The slave modport is the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic                 if_req;
    logic [ADDR_BITS-1:0] if_addr;
    logic [DATA_BITS-1:0] if_rdata;
    logic                 if_ack;
    logic [1:0]           mem_op;
    logic [ADDR_BITS-1:0] d_addr;
    logic [DATA_BITS-1:0] d_wdata;
    logic [DATA_BITS-1:0] d_rdata;
    logic                 d_ack;
    logic                 m_req;
    logic                 m_we;
    logic [ADDR_BITS-1:0] m_addr;
    logic [DATA_BITS-1:0] m_wdata;
    logic [DATA_BITS-1:0] m_rdata;
    logic                 m_ready;
    logic                 stall;

    modport master (
        output if_req, if_addr, mem_op, d_addr, d_wdata, m_rdata, m_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, stall
    );

    modport slave (
        input  if_req, if_addr, mem_op, d_addr, d_wdata, m_rdata, m_ready,
        output if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
// Optional feature: define MEM_ARB_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
//
//  state | meaning
//  IDLE  | no access in flight; pick a requester and latch its request
//  BUSY  | m_req held with the latched request until m_ready
//  DONE  | one-cycle ack to the granted port; requests are ignored
module mem_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic                 last_vld_q, last_vld_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_BITS-1:0] d_rdata_q, d_rdata_d;

    logic d_rd, d_wr, d_pend, sel, if_ack_w, d_ack_w, stall_w;

    // mem_op 11 is deliberately not a request
    assign d_rd   = (bus.mem_op == 2'b01);
    assign d_wr   = (bus.mem_op == 2'b10);
    assign d_pend = d_rd | d_wr;

    // Next-state and datapath capture for the arbitration FSM
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        last_vld_d   = last_vld_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        sel          = GNT_IF;
        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || d_pend) begin
                    // Data wins when alone, when nothing has been granted yet, or when fetch won last
                    if (d_pend && (!bus.if_req || !last_vld_q || last_grant_q == GNT_IF))
                        sel = GNT_D;
                    grant_d      = sel;
                    last_grant_d = sel;
                    last_vld_d   = 1'b1;
                    if (sel == GNT_D) begin
                        addr_d = bus.d_addr;
                        we_d   = d_wr;
                        if (d_wr)
                            wdata_d = bus.d_wdata;
                    end else begin
                        addr_d = bus.if_addr;
                        we_d   = 1'b0;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.m_ready) begin
                    // A store leaves d_rdata holding the previous load result
                    if (grant_q == GNT_IF)
                        if_rdata_d = bus.m_rdata;
                    else if (!we_q)
                        d_rdata_d = bus.m_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_IF;
            last_grant_q <= GNT_IF;
            last_vld_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            last_vld_q   <= last_vld_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_ack_w = (state_q == ST_DONE) && (grant_q == GNT_IF);
    assign d_ack_w  = (state_q == ST_DONE) && (grant_q == GNT_D);
    assign stall_w  = (bus.if_req & ~if_ack_w) | (d_pend & ~d_ack_w);

    assign bus.m_req    = (state_q == ST_BUSY);
    assign bus.m_we     = (state_q == ST_BUSY) & we_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_wdata  = wdata_q;
    assign bus.if_ack   = if_ack_w;
    assign bus.d_ack    = d_ack_w;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.stall    = stall_w;

`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 16, memory address width.
REQ-002 Parameter DATA_BITS, default 16, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-006 if_addr  input  ADDR_BITS  fetch address, stable while if_req high.
REQ-007 if_rdata  output  DATA_BITS  fetched word, valid when if_ack high.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 mem_op  input  2  data-port op: 00 none, 01 read, 10 write, 11 none.
REQ-010 d_addr  input  ADDR_BITS  data address, stable while mem_op active.
REQ-011 d_wdata  input  DATA_BITS  store data, stable while mem_op=10.
REQ-012 d_rdata  output  DATA_BITS  load result, valid when d_ack high after a read.
REQ-013 d_ack  output  1  one-cycle data-access completion pulse.
REQ-014 m_req  output  1  memory request, held until m_ready sampled high.
REQ-015 m_we  output  1  memory write enable, qualified by m_req.
REQ-016 m_addr  output  ADDR_BITS  memory address.
REQ-017 m_wdata  output  DATA_BITS  memory write data.
REQ-018 m_rdata  input  DATA_BITS  memory read data, valid with m_ready.
REQ-019 m_ready  input  1  memory completion, sampled only while m_req high.
REQ-020 stall  output  1  combinational: (if_req & ~if_ack) | (data op active & ~d_ack).

Function
REQ-021 FSM states IDLE, BUSY, DONE; exactly one requester granted per access.
REQ-022 IDLE: if any request pending, latch grant, address, we, wdata into registers; next state BUSY.
REQ-023 Both pending in IDLE: grant the requester not granted last (last_grant flag); if none granted since reset, data port wins.
REQ-024 BUSY: m_req=1, m_addr/m_we/m_wdata from latched values, unchanged until m_ready; on m_ready capture m_rdata into granted port's rdata register, next state DONE.
REQ-025 DONE: granted port's ack=1 for exactly one cycle, m_req=0, requests ignored; next state IDLE.
REQ-026 Minimum latency: request in cycle N -> m_req in N+1 -> ack in N+2 when m_ready high in N+1.
REQ-027 Write (mem_op=10): m_we=1; d_rdata retains previous value.
REQ-028 mem_op=11 SHALL be treated as no request.
REQ-029 m_we=0, m_addr/m_wdata hold last latched values whenever m_req=0.
REQ-030 Requesters SHALL change or drop a request only in the cycle after their ack; arbiter never acks a requester twice per access.
REQ-031 Request withdrawn before grant: ignored, no memory access issued.

Reset
REQ-032 On reset: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, last_grant=none.
REQ-033 Reset in BUSY or DONE aborts the access: m_req deasserts next edge, no ack issued.

Configuration
REQ-034 Macro MEM_ARB_STALL_CNT_EN defined: output stall_cnt (16 bits) increments each cycle stall=1, saturates at 16'hFFFF, cleared by reset.
REQ-035 Macro undefined: stall_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x0010, m_ready=1, m_rdata=0xABCD -> m_req cycle 1, if_ack and if_rdata=0xABCD cycle 2.
REQ-037 Store: mem_op=10, d_addr=0x0020, d_wdata=0x1234 -> m_req=1, m_we=1, m_addr=0x0020, m_wdata=0x1234; d_ack one cycle after m_ready; d_rdata unchanged.
REQ-038 Simultaneous if_req and mem_op=01 from reset -> data served first, fetch next; repeated contention alternates grants.
REQ-039 m_ready low 3 cycles in BUSY -> m_req and m_addr held stable 4 cycles, stall=1 throughout, ack only after m_ready.
REQ-040 reset asserted in BUSY -> next cycle m_req=0, no ack, outputs at reset values; mem_op=11 -> no m_req.
REQ-041 With MEM_ARB_STALL_CNT_EN: 5 stall cycles -> stall_cnt=5; counter forced to 16'hFFFF holds under further stalls.
